traffic_light_monitor: RTL

Passive checker on the lamp outputs of a traffic light controller. Decodes `red`/`yellow`/`green` back into a phase and checks the phase order. Measures each phase length against its programmed duration and reports sequence/timing violations as one-cycle pulses plus a saturating error count. Sits beside the controller in the top level or testbench and drives no lamp logic.

---
 rtl/types_pkg.sv | 42 ++++
 rtl/phase_duration_counter.sv | 30 +++
 rtl/traffic_light_monitor.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared light, lamp-pattern and monitor-state types
package types_pkg;

    typedef enum logic [2:0] {
        RED,
        RED_YELLOW,
        GREEN,
        GREEN_FLASH,
        YELLOW
    } light_color_e;

    typedef enum logic {
        UNSYNC,
        TRACK
    } mon_state_e;

    typedef enum logic [2:0] {
        LAMP_DARK,
        LAMP_RED,
        LAMP_RED_YELLOW,
        LAMP_GREEN,
        LAMP_YELLOW,
        LAMP_ILLEGAL
    } lamp_pattern_e;

    // Lamp bits are ordered {red, yellow, green}
    function automatic lamp_pattern_e decode_lamp(input logic [2:0] rgy);
        case (rgy)
            3'b000:  return LAMP_DARK;
            3'b100:  return LAMP_RED;
            3'b110:  return LAMP_RED_YELLOW;
            3'b001:  return LAMP_GREEN;
            3'b010:  return LAMP_YELLOW;
            default: return LAMP_ILLEGAL;
        endcase
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_duration_counter.sv
// rtl/phase_duration_counter.sv - load/increment/saturate phase length counter
module phase_duration_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] expected,
    output logic             mismatch,
    output logic             overrun
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign mismatch = (count != expected);
    // Fires only on the step from expected to expected+1, so at most once per phase
    assign overrun  = inc && (count == expected);

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase order and duration checker for traffic lamps
module traffic_light_monitor
    import types_pkg::*;
#(
    parameter int RED_TIME         = 10,
    parameter int RED_YELLOW_TIME  = 3,
    parameter int GREEN_TIME       = 10,
    parameter int GREEN_FLASH_TIME = 3,
    parameter int YELLOW_TIME      = 5,
    parameter int ERR_CNT_W        = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 red_i,
    input  logic                 yellow_i,
    input  logic                 green_i,
    output light_color_e         phase_o,
    output logic                 locked_o,
    output logic                 seq_err_o,
    output logic                 time_err_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int MAX_TIME = max_of(max_of(max_of(RED_TIME, RED_YELLOW_TIME),
                                            max_of(GREEN_TIME, GREEN_FLASH_TIME)), YELLOW_TIME);
    localparam int CNT_W    = $clog2(MAX_TIME + 2);

    if (RED_TIME < 1 || RED_YELLOW_TIME < 1 || GREEN_TIME < 1 ||
        GREEN_FLASH_TIME < 1 || YELLOW_TIME < 1) begin : g_bad_time
        $error("traffic_light_monitor: every *_TIME parameter must be at least 1");
    end

    logic [2:0]           lamp_q;
    lamp_pattern_e        pat, last_pat_q;
    mon_state_e           state_q, state_d;
    light_color_e         phase_q, phase_d, next_phase;
    logic                 seq_err_q, seq_err_d;
    logic                 time_err_q, time_err_d;
    logic                 ovr_seen_q, ovr_seen_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 stay, advance;
    logic                 cnt_load, cnt_inc;
    logic [CNT_W-1:0]     expected;
    logic                 mismatch, overrun;

    assign pat = decode_lamp(lamp_q);

    always_comb begin
        expected = CNT_W'(RED_TIME);
        case (phase_q)
            RED_YELLOW:  expected = CNT_W'(RED_YELLOW_TIME);
            GREEN:       expected = CNT_W'(GREEN_TIME);
            GREEN_FLASH: expected = CNT_W'(GREEN_FLASH_TIME);
            YELLOW:      expected = CNT_W'(YELLOW_TIME);
            default:     expected = CNT_W'(RED_TIME);
        endcase
    end

    phase_duration_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (cnt_load),
        .inc      (cnt_inc),
        .expected (expected),
        .mismatch (mismatch),
        .overrun  (overrun)
    );

    // Which patterns hold the current phase and which one legally ends it
    always_comb begin
        stay       = 1'b0;
        advance    = 1'b0;
        next_phase = phase_q;
        case (phase_q)
            RED: begin
                stay       = (pat == LAMP_RED);
                advance    = (pat == LAMP_RED_YELLOW);
                next_phase = RED_YELLOW;
            end
            RED_YELLOW: begin
                stay       = (pat == LAMP_RED_YELLOW);
                advance    = (pat == LAMP_GREEN);
                next_phase = GREEN;
            end
            GREEN: begin
                stay       = (pat == LAMP_GREEN);
                advance    = (pat == LAMP_DARK);
                next_phase = GREEN_FLASH;
            end
            GREEN_FLASH: begin
                stay       = (pat == LAMP_GREEN) || (pat == LAMP_DARK);
                advance    = (pat == LAMP_YELLOW);
                next_phase = YELLOW;
            end
            YELLOW: begin
                stay       = (pat == LAMP_YELLOW);
                advance    = (pat == LAMP_RED);
                next_phase = RED;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        seq_err_d  = 1'b0;
        time_err_d = 1'b0;
        ovr_seen_d = ovr_seen_q;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            UNSYNC: begin
                if (pat == LAMP_RED && last_pat_q != LAMP_RED) begin
                    state_d    = TRACK;
                    phase_d    = RED;
                    cnt_load   = 1'b1;
                    ovr_seen_d = 1'b0;
                end
            end
            TRACK: begin
                if (stay) begin
                    cnt_inc = 1'b1;
                    if (overrun) begin
                        time_err_d = 1'b1;
                        ovr_seen_d = 1'b1;
                    end
                end else if (advance) begin
                    phase_d    = next_phase;
                    cnt_load   = 1'b1;
                    ovr_seen_d = 1'b0;
                    // A stuck lamp already reported at overrun is not reported again at exit
                    time_err_d = mismatch && !ovr_seen_q;
                end else begin
                    seq_err_d = 1'b1;
                    state_d   = UNSYNC;
                end
            end
        endcase
        err_cnt_d = err_cnt_q;
        if ((seq_err_d || time_err_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lamp_q     <= 3'b100;
            last_pat_q <= LAMP_RED;
            state_q    <= UNSYNC;
            phase_q    <= RED;
            seq_err_q  <= 1'b0;
            time_err_q <= 1'b0;
            ovr_seen_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            lamp_q     <= {red_i, yellow_i, green_i};
            last_pat_q <= pat;
            state_q    <= state_d;
            phase_q    <= phase_d;
            seq_err_q  <= seq_err_d;
            time_err_q <= time_err_d;
            ovr_seen_q <= ovr_seen_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign phase_o     = phase_q;
    assign locked_o    = (state_q == TRACK);
    assign seq_err_o   = seq_err_q;
    assign time_err_o  = time_err_q;
    assign err_count_o = err_cnt_q;

endmodule
